// File: rtl/wb_spi_master_bridge.sv
// Wishbone slave to SPI master bridge: each bus access becomes one 112-bit frame.
// Define WB_SPI_MASTER_BRIDGE_RETRY_EN to re-send failed reads up to MAX_RETRY times.
module wb_spi_master_bridge #(
    parameter int LITTLE_ENDIAN = 1,
    parameter int SCLK_HALF     = 8,
    parameter int CS_GAP        = 16,
    parameter int MAX_RETRY     = 3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        busy
);

    localparam int CW = 16;
    localparam logic [CW-1:0] HALF    = CW'(SCLK_HALF);
    localparam logic [CW-1:0] HALF_M1 = CW'(SCLK_HALF - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(2 * SCLK_HALF - 1);
    localparam logic [CW-1:0] GAP_M1  = CW'(CS_GAP - 1);
    localparam logic [CW-1:0] GAP_RST = CW'(CS_GAP);

    typedef enum logic [2:0] {
        IDLE, SETUP, SHIFT, HOLD, RESP, GAP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    bit_q, bit_d;
    logic [111:0]  frame_q, frame_d;
    logic [39:0]   resp_q, resp_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic          miso_s1_q, miso_s2_q;
    logic          cs_n_q, cs_n_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [31:0]   dat_q, dat_d;

    logic          req;
    logic          rd_pass;
    logic          hi_phase;
    logic          retry_go;
    logic          again;
    logic [31:0]   adr_w;
    logic [31:0]   dat_w;
    logic [31:0]   rdata_w;
    logic          unused_bits;

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    assign req      = wbs_cyc_i & wbs_stb_i;
    assign adr_w    = (LITTLE_ENDIAN != 0) ? bswap(wbs_adr_i) : wbs_adr_i;
    assign dat_w    = (LITTLE_ENDIAN != 0) ? bswap(wbs_dat_i) : wbs_dat_i;
    assign rdata_w  = (LITTLE_ENDIAN != 0) ? bswap(resp_q[39:8]) : resp_q[39:8];
    assign rd_pass  = resp_q[7] & ~resp_q[6] & (resp_q[3:0] == sel_q);
    assign hi_phase = (cnt_q >= HALF);
    assign unused_bits = ^{resp_q[5:4], MAX_RETRY[0]};

`ifdef WB_SPI_MASTER_BRIDGE_RETRY_EN
    logic [1:0] retry_q, retry_d;
    logic       again_q, again_d;

    assign retry_go = ~we_q & ~rd_pass & wbs_cyc_i
                      & ({30'b0, retry_q} < 32'(MAX_RETRY));
    assign again    = again_q;

    always_comb begin
        retry_d = retry_q;
        again_d = again_q;
        if (state_q == IDLE && cnt_q == '0 && req) begin
            retry_d = '0;
            again_d = 1'b0;
        end
        if (state_q == RESP) begin
            again_d = retry_go;
            if (retry_go) retry_d = retry_q + 2'd1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            retry_q <= '0;
            again_q <= 1'b0;
        end else begin
            retry_q <= retry_d;
            again_q <= again_d;
        end
    end
`else
    assign retry_go = 1'b0;
    assign again    = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        resp_d  = resp_q;
        we_d    = we_q;
        sel_d   = sel_q;
        unique case (state_q)
            IDLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (req) begin
                    state_d = SETUP;
                    cnt_d   = HALF_M1;
                    we_d    = wbs_we_i;
                    sel_d   = wbs_sel_i;
                    frame_d = {wbs_we_i, 3'b000, wbs_sel_i, adr_w,
                               wbs_we_i ? dat_w : 32'h0, 32'h0, 8'h01};
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = SHIFT;
                    cnt_d   = BIT_M1;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SHIFT: begin
                // the last 40 bits shifted in are the response field
                if (cnt_q == HALF_M1) resp_d = {resp_q[38:0], miso_s2_q};
                if (cnt_q == '0) begin
                    if (bit_q == 7'd111) begin
                        state_d = HOLD;
                        cnt_d   = HALF_M1;
                    end else begin
                        bit_d = bit_q + 7'd1;
                        cnt_d = BIT_M1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            RESP: begin
                state_d = GAP;
                cnt_d   = GAP_M1;
            end
            GAP: begin
                if (cnt_q == '0) begin
                    if (again) begin
                        state_d = SETUP;
                        cnt_d   = HALF_M1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // outputs are registered, so the pins trail the state by one cycle
    always_comb begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        ack_d  = 1'b0;
        err_d  = 1'b0;
        dat_d  = dat_q;
        unique case (state_q)
            SETUP: begin
                cs_n_d = 1'b0;
                mosi_d = frame_q[111];
            end
            SHIFT: begin
                cs_n_d = 1'b0;
                sclk_d = hi_phase;
                if (hi_phase)              mosi_d = frame_q[7'd111 - bit_q];
                else if (bit_q != 7'd111)  mosi_d = frame_q[7'd110 - bit_q];
            end
            HOLD: cs_n_d = 1'b0;
            RESP: begin
                if (wbs_cyc_i && !retry_go) begin
                    if (we_q) begin
                        ack_d = 1'b1;
                    end else if (rd_pass) begin
                        ack_d = 1'b1;
                        dat_d = rdata_w;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q     <= GAP_RST;
            bit_q     <= '0;
            frame_q   <= '0;
            resp_q    <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            frame_q   <= frame_d;
            resp_q    <= resp_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            miso_s1_q <= spi_miso;
            miso_s2_q <= miso_s1_q;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            dat_q     <= dat_d;
        end
    end

    assign spi_cs_n  = cs_n_q;
    assign spi_sclk  = sclk_q;
    assign spi_mosi  = mosi_q;
    assign wbs_ack_o = ack_q;
    assign wbs_err_o = err_q;
    assign wbs_dat_o = dat_q;
    assign busy      = (state_q != IDLE);

endmodule
